// File: rtl/ld_cell_filt.sv
// Load-cell conditioner: per-cell box-car average, zero-offset subtraction, signed 12-bit
// saturation, on-demand offset calibration and a per-cell dead-cell watchdog.
module ld_cell_filt #(
  parameter int LOG2_AVG  = 2,
  parameter int STALE_CYC = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        smpl_vld,
  input  logic        smpl_chnl,
  input  logic [11:0] smpl_data,
  input  logic        cal_req,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic        ld_vld,
  output logic        cal_busy,
  output logic        cal_done,
  output logic        cal_fail,
  output logic [1:0]  ld_stale
);

  localparam int AW = 12 + LOG2_AVG;
  localparam int CW = (LOG2_AVG > 0) ? LOG2_AVG : 1;
  localparam int WW = $clog2(STALE_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << LOG2_AVG) - 1);
  localparam logic [WW-1:0] WD_MAX   = WW'(STALE_CYC);
  localparam logic [WW-1:0] WD_EXP   = WW'(STALE_CYC - 1);

  typedef enum logic {ST_RUN, ST_CAL} state_t;

  state_t               state_q, state_d;
  logic [1:0][AW-1:0]   acc_q, acc_d;
  logic [1:0][CW-1:0]   cnt_q, cnt_d;
  logic [1:0][WW-1:0]   wd_q, wd_d;
  logic [1:0][11:0]     ld_q, ld_d;
  logic [1:0][11:0]     off_q, off_d;
  logic [1:0]           stale_q, stale_d;
  logic [1:0]           fresh_q, fresh_d;
  logic                 ld_vld_q, ld_vld_d;
  logic                 cal_done_q, cal_done_d;
  logic                 cal_fail_q, cal_fail_d;

  logic                 enter_cal;
  logic [1:0]           hit, expire, last;
  logic [1:0][AW-1:0]   sum;
  logic [1:0][11:0]     sat_ld;

  function automatic logic [11:0] sat12(input logic signed [12:0] v);
    if (v > 13'sd2047)
      return 12'h7ff;
    else if (v < -13'sd2048)
      return 12'h800;
    else
      return v[11:0];
  endfunction

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    wd_d       = wd_q;
    ld_d       = ld_q;
    off_d      = off_q;
    stale_d    = stale_q;
    fresh_d    = fresh_q;
    ld_vld_d   = 1'b0;
    cal_done_d = 1'b0;
    cal_fail_d = 1'b0;
    enter_cal  = (state_q == ST_RUN) && cal_req;
    hit        = '0;
    expire     = '0;
    last       = '0;
    sum        = '0;
    sat_ld     = '0;

    // A sample in the cycle that starts calibration is discarded and does not feed the watchdog.
    for (int c = 0; c < 2; c++) begin
      hit[c]    = smpl_vld && !enter_cal && (smpl_chnl == 1'(c));
      expire[c] = !hit[c] && (wd_q[c] == WD_EXP);
      last[c]   = hit[c] && (cnt_q[c] == CNT_LAST);
      sum[c]    = acc_q[c] + AW'(smpl_data);
      sat_ld[c] = sat12($signed({1'b0, sum[c][LOG2_AVG +: 12]}) - $signed({1'b0, off_q[c]}));
      if (hit[c]) begin
        wd_d[c]    = '0;
        stale_d[c] = 1'b0;
      end else if (wd_q[c] != WD_MAX) begin
        wd_d[c] = wd_q[c] + WW'(1);
      end
      if (expire[c]) begin
        stale_d[c] = 1'b1;
        ld_d[c]    = '0;
      end
    end

    if (state_q == ST_RUN) begin
      if (enter_cal) begin
        state_d = ST_CAL;
        acc_d   = '0;
        cnt_d   = '0;
        fresh_d = '0;
      end else begin
        ld_vld_d = &fresh_q;
        if (&fresh_q)
          fresh_d = '0;
        for (int c = 0; c < 2; c++) begin
          if (last[c]) begin
            ld_d[c]    = sat_ld[c];
            acc_d[c]   = '0;
            cnt_d[c]   = '0;
            fresh_d[c] = 1'b1;
          end else if (hit[c]) begin
            acc_d[c] = sum[c];
            cnt_d[c] = cnt_q[c] + CW'(1);
          end else if (expire[c]) begin
            acc_d[c]   = '0;
            cnt_d[c]   = '0;
            fresh_d[c] = 1'b0;
          end
        end
      end
    end else begin
      // In CAL the fresh bits mark a cell that already holds its full set of samples.
      for (int c = 0; c < 2; c++) begin
        if (hit[c] && !fresh_q[c]) begin
          acc_d[c] = sum[c];
          if (last[c]) begin
            cnt_d[c]   = '0;
            fresh_d[c] = 1'b1;
          end else begin
            cnt_d[c] = cnt_q[c] + CW'(1);
          end
        end
      end
      if (&fresh_d) begin
        for (int c = 0; c < 2; c++)
          off_d[c] = acc_d[c][LOG2_AVG +: 12];
        cal_done_d = 1'b1;
        state_d    = ST_RUN;
        acc_d      = '0;
        cnt_d      = '0;
        fresh_d    = '0;
      end else if (|expire) begin
        cal_fail_d = 1'b1;
        state_d    = ST_RUN;
        acc_d      = '0;
        cnt_d      = '0;
        fresh_d    = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      acc_q      <= '0;
      cnt_q      <= '0;
      wd_q       <= '0;
      ld_q       <= '0;
      off_q      <= '0;
      stale_q    <= '0;
      fresh_q    <= '0;
      ld_vld_q   <= 1'b0;
      cal_done_q <= 1'b0;
      cal_fail_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      wd_q       <= wd_d;
      ld_q       <= ld_d;
      off_q      <= off_d;
      stale_q    <= stale_d;
      fresh_q    <= fresh_d;
      ld_vld_q   <= ld_vld_d;
      cal_done_q <= cal_done_d;
      cal_fail_q <= cal_fail_d;
    end
  end

  assign lft_ld   = ld_q[0];
  assign rght_ld  = ld_q[1];
  assign ld_vld   = ld_vld_q;
  assign cal_busy = (state_q == ST_CAL);
  assign cal_done = cal_done_q;
  assign cal_fail = cal_fail_q;
  assign ld_stale = stale_q;

endmodule

// File: tb/tb_ld_cell_filt.sv
// Scoreboard bench for ld_cell_filt: stimulus pushes expected load pairs and calibration
// outcomes; a negedge monitor pops and compares whenever ld_vld or cal_done/cal_fail fires.
module tb_ld_cell_filt;
  localparam int L2    = 2;
  localparam int STALE = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        smpl_vld = 1'b0;
  logic        smpl_chnl = 1'b0;
  logic [11:0] smpl_data = '0;
  logic        cal_req = 1'b0;
  logic [11:0] lft_ld, rght_ld;
  logic        ld_vld, cal_busy, cal_done, cal_fail;
  logic [1:0]  ld_stale;

  typedef struct { int lft; int rght; } ldExp_t;
  ldExp_t     ldQueue[$];
  logic [1:0] calQueue[$];
  ldExp_t     monExp;
  logic [1:0] monCal;
  int passCount = 0;
  int checkCount = 0;

  ld_cell_filt #(.LOG2_AVG(L2), .STALE_CYC(STALE)) dut (
    .clk(clk), .rst(rst), .smpl_vld(smpl_vld), .smpl_chnl(smpl_chnl),
    .smpl_data(smpl_data), .cal_req(cal_req), .lft_ld(lft_ld), .rght_ld(rght_ld),
    .ld_vld(ld_vld), .cal_busy(cal_busy), .cal_done(cal_done), .cal_fail(cal_fail),
    .ld_stale(ld_stale)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected)
      passCount++;
    else
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic chnl, input int data);
    smpl_vld  = 1'b1;
    smpl_chnl = chnl;
    smpl_data = 12'(data);
    @(posedge clk); #1;
    smpl_vld  = 1'b0;
  endtask

  task automatic sendBlock(input logic chnl, input int data, input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(chnl, data);
  endtask

  task automatic calReq();
    cal_req = 1'b1;
    @(posedge clk); #1;
    cal_req = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic waitCalIdle();
    int n = 0;
    while (cal_busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("cal_busy timeout", int'(cal_busy), 0);
  endtask

  task automatic pushLd(input int l, input int r);
    ldExp_t e;
    e.lft  = l;
    e.rght = r;
    ldQueue.push_back(e);
  endtask

  // Monitor: every output event must match the next expectation in order.
  always @(negedge clk) begin
    if (!rst) begin
      if (ld_vld) begin
        if (ldQueue.size() == 0) begin
          checkOutput("unexpected ld_vld", 1, 0);
        end else begin
          monExp = ldQueue.pop_front();
          checkOutput("lft_ld", int'($signed(lft_ld)), monExp.lft);
          checkOutput("rght_ld", int'($signed(rght_ld)), monExp.rght);
        end
      end
      if (cal_done || cal_fail) begin
        if (calQueue.size() == 0) begin
          checkOutput("unexpected cal event", 1, 0);
        end else begin
          monCal = calQueue.pop_front();
          checkOutput("cal {done,fail}", int'({cal_done, cal_fail}), int'(monCal));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global timeout");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    repeat (2) @(posedge clk); #1;
    checkOutput("reset lft_ld", int'(lft_ld), 0);
    checkOutput("reset rght_ld", int'(rght_ld), 0);
    checkOutput("reset ld_vld", int'(ld_vld), 0);
    checkOutput("reset cal_busy", int'(cal_busy), 0);
    checkOutput("reset cal_done", int'(cal_done), 0);
    checkOutput("reset cal_fail", int'(cal_fail), 0);
    checkOutput("reset ld_stale", int'(ld_stale), 0);
    rst = 1'b0;
    waitCycles(1);

    // Interleaved averaging: (100+200+300+400)/4 = 250, right 800, one pulse.
    pushLd(250, 800);
    applyStimulus(0, 100); applyStimulus(1, 800);
    applyStimulus(0, 200); applyStimulus(1, 800);
    applyStimulus(0, 300); applyStimulus(1, 800);
    applyStimulus(0, 400); applyStimulus(1, 800);
    waitCycles(4);

    // Calibrate to 512/520; a fifth left sample must be ignored.
    calReq();
    checkOutput("cal_busy after cal_req", int'(cal_busy), 1);
    calQueue.push_back(2'b10);
    sendBlock(0, 512, 4);
    applyStimulus(0, 4000);
    sendBlock(1, 520, 4);
    waitCalIdle();
    pushLd(88, -520);
    sendBlock(0, 600, 4);
    sendBlock(1, 0, 4);
    waitCycles(4);

    // Reset mid-calibration drops offsets.
    calReq();
    sendBlock(0, 100, 2);
    rst = 1'b1;
    #1;
    checkOutput("midcal reset lft_ld", int'(lft_ld), 0);
    checkOutput("midcal reset rght_ld", int'(rght_ld), 0);
    checkOutput("midcal reset cal_busy", int'(cal_busy), 0);
    checkOutput("midcal reset ld_stale", int'(ld_stale), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    pushLd(100, 2047);
    sendBlock(0, 100, 4);
    sendBlock(1, 4095, 4);
    waitCycles(4);

    // Offsets 3000: 0-3000 saturates low, 4095-3000 = 1095.
    calReq();
    calQueue.push_back(2'b10);
    sendBlock(0, 3000, 4);
    sendBlock(1, 3000, 4);
    waitCalIdle();
    pushLd(-2048, 1095);
    sendBlock(0, 0, 4);
    sendBlock(1, 4095, 4);
    waitCycles(4);

    // Right watchdog: last right sample at k=0, stale exactly 64 edges later.
    applyStimulus(1, 4095);
    for (int k = 1; k <= 66; k++) begin
      if (k % 8 == 0) begin
        smpl_vld  = 1'b1;
        smpl_chnl = 1'b0;
        smpl_data = 12'd100;
      end
      @(posedge clk); #1;
      smpl_vld = 1'b0;
      if (k == 63) begin
        checkOutput("ld_stale before expiry", int'(ld_stale), 0);
        checkOutput("rght_ld before expiry", int'($signed(rght_ld)), 1095);
      end
      if (k == 64) begin
        checkOutput("ld_stale at expiry", int'(ld_stale), 2);
        checkOutput("rght_ld at expiry", int'($signed(rght_ld)), 0);
      end
    end
    pushLd(-2048, 100);
    applyStimulus(1, 3100);
    checkOutput("ld_stale after right sample", int'(ld_stale), 0);
    sendBlock(1, 3100, 3);
    waitCycles(4);

    // cal_req colliding with a right sample of 0: the sample must not enter the offset.
    cal_req   = 1'b1;
    smpl_vld  = 1'b1;
    smpl_chnl = 1'b1;
    smpl_data = 12'd0;
    @(posedge clk); #1;
    cal_req  = 1'b0;
    smpl_vld = 1'b0;
    checkOutput("cal_busy after collide", int'(cal_busy), 1);
    calQueue.push_back(2'b10);
    sendBlock(0, 3000, 4);
    sendBlock(1, 3000, 4);
    waitCalIdle();
    pushLd(100, 100);
    sendBlock(0, 3100, 4);
    sendBlock(1, 3100, 4);
    waitCycles(4);

    // Right goes stale during CAL: abort with offsets kept at 3000/3000.
    calQueue.push_back(2'b01);
    calReq();
    sendBlock(0, 1000, 4);
    waitCalIdle();
    pushLd(100, 200);
    sendBlock(0, 3100, 4);
    sendBlock(1, 3200, 4);
    waitCycles(5);

    checkOutput("ld queue drained", ldQueue.size(), 0);
    checkOutput("cal queue drained", calQueue.size(), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
